// File: rtl/dt_skeleton.sv
// Medial-axis extraction over the 128x128 distance map: a pixel is kept when it is
// non-zero and not smaller than any of its 8 neighbours; results are packed 16 per word.
module dt_skeleton (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        skel_wr,
    output logic [9:0]  skel_addr,
    output logic [15:0] skel_do,
    output logic [13:0] skel_cnt,
    output logic [7:0]  max_dist
);

    typedef enum logic [2:0] {IDLE, RD_C, CHK, RD_N, CMP, WR, DONE} state_t;

    state_t      state_q;
    logic [13:0] p_q;
    logic [7:0]  d_q;
    logic        ge_q;
    logic [2:0]  k_q;
    logic        rd_prev_q;
    logic [14:0] shift_q;
    logic        done_q;
    logic        res_rd_q;
    logic [13:0] res_addr_q;
    logic        skel_wr_q;
    logic [9:0]  skel_addr_q;
    logic [15:0] skel_do_q;
    logic [13:0] skel_cnt_q;
    logic [7:0]  max_dist_q;

    // Neighbour slot k (NW,N,NE,W,E,SW,S,SE) of pixel p: {in_image, address}.
    function automatic logic [14:0] nbr(input logic [13:0] p, input logic [2:0] k);
        logic [6:0]  r;
        logic [6:0]  c;
        logic        ok;
        logic [13:0] a;
        r = p[13:7];
        c = p[6:0];
        case (k)
            3'd0:    begin ok = (r != 7'd0)   && (c != 7'd0);   a = p - 14'd129; end
            3'd1:    begin ok = (r != 7'd0);                    a = p - 14'd128; end
            3'd2:    begin ok = (r != 7'd0)   && (c != 7'd127); a = p - 14'd127; end
            3'd3:    begin ok = (c != 7'd0);                    a = p - 14'd1;   end
            3'd4:    begin ok = (c != 7'd127);                  a = p + 14'd1;   end
            3'd5:    begin ok = (r != 7'd127) && (c != 7'd0);   a = p + 14'd127; end
            3'd6:    begin ok = (r != 7'd127);                  a = p + 14'd128; end
            default: begin ok = (r != 7'd127) && (c != 7'd127); a = p + 14'd129; end
        endcase
        return {ok, ok ? a : 14'd0};
    endfunction

    logic [2:0]  nbr_sel_d;
    logic [14:0] nbr_issue_d;
    logic [7:0]  nb_val_d;
    logic        nb_gt_d;
    logic        cmp_bit_d;
    logic        pix_bit_d;
    logic        adv_d;
    logic [15:0] shift_d;
    logic [13:0] p_inc_d;

    // NOTE: every signal in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        nbr_sel_d = k_q + 3'd1;
        if (state_q == RD_C) nbr_sel_d = 3'd0;
        if (state_q == CHK)  nbr_sel_d = 3'd1;
        nbr_issue_d = nbr(p_q, nbr_sel_d);
        // Slots with no read (out of image) count as distance 0.
        nb_val_d  = rd_prev_q ? res_di : 8'd0;
        nb_gt_d   = nb_val_d > d_q;
        cmp_bit_d = ge_q & ~nb_gt_d;
        pix_bit_d = (state_q == CMP) ? cmp_bit_d : 1'b0;
        adv_d     = ((state_q == CHK) && (res_di == 8'd0)) || (state_q == CMP);
        shift_d   = {shift_q, pix_bit_d};
        p_inc_d   = p_q + 14'd1;
    end

    // The NW read is issued while CHK decides on d; for a zero pixel it is simply dropped.
    // NOTE: state is updated with non-blocking assignments; the pixel-advance block at the
    // bottom deliberately overrides the per-state assignments made earlier in the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            p_q         <= 14'd0;
            d_q         <= 8'd0;
            ge_q        <= 1'b0;
            k_q         <= 3'd0;
            rd_prev_q   <= 1'b0;
            shift_q     <= 15'd0;
            done_q      <= 1'b0;
            res_rd_q    <= 1'b0;
            res_addr_q  <= 14'd0;
            skel_wr_q   <= 1'b0;
            skel_addr_q <= 10'd0;
            skel_do_q   <= 16'd0;
            skel_cnt_q  <= 14'd0;
            max_dist_q  <= 8'd0;
        end else begin
            rd_prev_q <= res_rd_q;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        p_q        <= 14'd0;
                        shift_q    <= 15'd0;
                        skel_cnt_q <= 14'd0;
                        max_dist_q <= 8'd0;
                        done_q     <= 1'b0;
                        res_rd_q   <= 1'b1;
                        res_addr_q <= 14'd0;
                        state_q    <= RD_C;
                    end
                end
                RD_C: begin
                    {res_rd_q, res_addr_q} <= nbr_issue_d;
                    state_q <= CHK;
                end
                CHK: begin
                    d_q  <= res_di;
                    ge_q <= 1'b1;
                    if (res_di > max_dist_q) max_dist_q <= res_di;
                    if (res_di != 8'd0) begin
                        {res_rd_q, res_addr_q} <= nbr_issue_d;
                        k_q     <= 3'd1;
                        state_q <= RD_N;
                    end
                end
                RD_N: begin
                    if (nb_gt_d) ge_q <= 1'b0;
                    if (k_q == 3'd7) begin
                        res_rd_q   <= 1'b0;
                        res_addr_q <= 14'd0;
                        state_q    <= CMP;
                    end else begin
                        {res_rd_q, res_addr_q} <= nbr_issue_d;
                        k_q <= k_q + 3'd1;
                    end
                end
                CMP: begin
                    if (cmp_bit_d) skel_cnt_q <= skel_cnt_q + 14'd1;
                end
                WR: begin
                    skel_wr_q <= 1'b0;
                    p_q       <= p_inc_d;
                    if (p_q == 14'h3FFF) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        res_rd_q   <= 1'b1;
                        res_addr_q <= p_inc_d;
                        state_q    <= RD_C;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (adv_d) begin
                shift_q <= shift_d[14:0];
                if (p_q[3:0] == 4'hF) begin
                    skel_wr_q   <= 1'b1;
                    skel_addr_q <= p_q[13:4];
                    skel_do_q   <= shift_d;
                    res_rd_q    <= 1'b0;
                    res_addr_q  <= 14'd0;
                    state_q     <= WR;
                end else begin
                    p_q        <= p_inc_d;
                    res_rd_q   <= 1'b1;
                    res_addr_q <= p_inc_d;
                    state_q    <= RD_C;
                end
            end
        end
    end

    assign done      = done_q;
    assign res_rd    = res_rd_q;
    assign res_addr  = res_addr_q;
    assign skel_wr   = skel_wr_q;
    assign skel_addr = skel_addr_q;
    assign skel_do   = skel_do_q;
    assign skel_cnt  = skel_cnt_q;
    assign max_dist  = max_dist_q;

endmodule

// File: tb/tb_dt_skeleton.sv
// Directed bench for dt_skeleton: a behavioural result RAM, a write monitor, and
// hand-computed expectations for word contents, counts and DONE timing.
module tb_dt_skeleton;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        done;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        skel_wr;
    logic [9:0]  skel_addr;
    logic [15:0] skel_do;
    logic [13:0] skel_cnt;
    logic [7:0]  max_dist;

    always #5 clk = ~clk;

    dt_skeleton dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .done      (done),
        .res_rd    (res_rd),
        .res_addr  (res_addr),
        .res_di    (res_di),
        .skel_wr   (skel_wr),
        .skel_addr (skel_addr),
        .skel_do   (skel_do),
        .skel_cnt  (skel_cnt),
        .max_dist  (max_dist)
    );

    logic [7:0]  mem [16384];
    logic [15:0] skel [1024];
    logic        mon_clr = 1'b0;
    int          wr_cnt;
    int          ord_err;
    int          ovl_cnt;
    logic        rec_rd   [10];
    logic [13:0] rec_addr [10];
    int          errors = 0;
    int          checks = 0;

    // Result RAM: one-cycle read latency; junk data when not read.
    always @(posedge clk) res_di <= res_rd ? mem[res_addr] : 8'hFF;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_cnt  = 0;
            ord_err = 0;
            ovl_cnt = 0;
            for (int i = 0; i < 1024; i++) skel[i] = 16'h0;
        end else begin
            if (res_rd && skel_wr) ovl_cnt++;
            if (skel_wr) begin
                if (int'(skel_addr) != (wr_cnt % 1024)) ord_err++;
                skel[skel_addr] = skel_do;
                wr_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_res_rd"},    32'(res_rd), 0);
        check({tag, "_res_addr"},  32'(res_addr), 0);
        check({tag, "_skel_wr"},   32'(skel_wr), 0);
        check({tag, "_skel_addr"}, 32'(skel_addr), 0);
        check({tag, "_skel_do"},   32'(skel_do), 0);
        check({tag, "_skel_cnt"},  32'(skel_cnt), 0);
        check({tag, "_max_dist"},  32'(max_dist), 0);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // cyc counts edges after the start edge; a second start pulse is driven at cyc==repulse.
    task automatic wait_done(input int limit, input int repulse, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            if (cyc < 10) begin
                rec_rd[cyc]   = res_rd;
                rec_addr[cyc] = res_addr;
            end
            start = (cyc == repulse);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    function automatic logic [15:0] exp_word(input bit map_a, input int w);
        if (w == 90) return 16'h4000;
        if (map_a && w == 0)  return 16'hC000;
        if (map_a && w == 41) return 16'h0800;
        return 16'h0000;
    endfunction

    task automatic check_words(input string tag, input bit map_a);
        int bad;
        bad = 0;
        for (int w = 0; w < 1024; w++)
            if (skel[w] !== exp_word(map_a, w)) bad++;
        check({tag, "_w90"}, 32'(skel[90]), 32'h4000);
        if (map_a) begin
            check({tag, "_w0"},  32'(skel[0]),  32'hC000);
            check({tag, "_w41"}, 32'(skel[41]), 32'h0800);
        end
        check({tag, "_bad_words"}, 32'(bad), 0);
    endtask

    task automatic load_patch();
        for (int r = 10; r <= 12; r++)
            for (int c = 32; c <= 34; c++) mem[r*128 + c] = 8'd1;
        mem[11*128 + 33] = 8'd2;
    endtask

    task automatic clear_map();
        for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    endtask

    logic        exp_rd   [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [13:0] exp_addr [10] = '{14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd1, 14'd0, 14'd128, 14'd129, 14'd0};

    initial begin
        int cyc;
        int nz;
        rst_n = 1'b0;
        start = 1'b0;
        clear_map();
        repeat (3) @(negedge clk);
        check_reset_values("rst0");
        rst_n = 1'b1;

        // Map A: single pixel, 3x3 patch and corner plateau together.
        mem[5*128 + 20] = 8'd1;
        load_patch();
        mem[0] = 8'd1;
        mem[1] = 8'd1;
        clear_mon();
        do_start();
        wait_done(40000, 100, cyc);
        check("A_done_time", 32'(cyc), 33888);
        check("A_writes", 32'(wr_cnt), 1024);
        check("A_order", 32'(ord_err), 0);
        check("A_overlap", 32'(ovl_cnt), 0);
        check("A_skel_cnt", 32'(skel_cnt), 4);
        check("A_max_dist", 32'(max_dist), 2);
        check_words("A", 1'b1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("A_slot%0d_rd", i), 32'(rec_rd[i]), 32'(exp_rd[i]));
            check($sformatf("A_slot%0d_addr", i), 32'(rec_addr[i]), 32'(exp_addr[i]));
        end
        repeat (5) @(negedge clk);
        check("A_done_hold", 32'(done), 1);
        check("A_cnt_hold", 32'(skel_cnt), 4);
        check("A_rd_idle", 32'(res_rd), 0);

        // Map B: all-zero rescan from DONE, aborted by reset during WR of word 500.
        clear_map();
        clear_mon();
        do_start();
        check("B_done_drop", 32'(done), 0);
        cyc = 0;
        while (!(skel_wr && skel_addr == 10'd500) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("B_wr500_time", 32'(cyc), 16532);
        check("B_writes", 32'(wr_cnt), 500);
        check("B_order", 32'(ord_err), 0);
        nz = 0;
        for (int w = 0; w < 500; w++) if (skel[w] !== 16'h0) nz++;
        check("B_nonzero", 32'(nz), 0);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst1");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        check("B_idle_writes", 32'(wr_cnt), 0);
        check("B_idle_done", 32'(done), 0);
        check("B_idle_rd", 32'(res_rd), 0);

        // Map C: the 3x3 patch alone, after the reset.
        load_patch();
        clear_mon();
        do_start();
        wait_done(40000, -1, cyc);
        check("C_done_time", 32'(cyc), 33864);
        check("C_writes", 32'(wr_cnt), 1024);
        check("C_order", 32'(ord_err), 0);
        check("C_overlap", 32'(ovl_cnt), 0);
        check("C_skel_cnt", 32'(skel_cnt), 1);
        check("C_max_dist", 32'(max_dist), 2);
        check_words("C", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
